// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
// Holds the FSM state encoding, the default strobe timing and the counter-load helper.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WR_SU = 3'd2,
      S_WR_PL = 3'd3,
      S_WR_HD = 3'd4
   } state_e;

   localparam int unsigned DEF_READ_WAIT = 2;
   localparam int unsigned DEF_WR_SETUP  = 1;
   localparam int unsigned DEF_WR_PULSE  = 2;
   localparam int unsigned DEF_WR_HOLD   = 1;

   // A phase lasting N cycles starts its down-counter at N-1 and leaves when it reads zero.
   function automatic logic [3:0] cntLoad(input int unsigned cycles);
      return 4'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Responder for one word-wide memory request port, driving one asynchronous external SRAM.
// Every pin output, including the data-bus enable, comes straight from a flop so strobes are glitch-free.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned READ_WAIT = DEF_READ_WAIT,
   parameter int unsigned WR_SETUP  = DEF_WR_SETUP,
   parameter int unsigned WR_PULSE  = DEF_WR_PULSE,
   parameter int unsigned WR_HOLD   = DEF_WR_HOLD
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   inout  wire  [31:0] ram_data,
   output logic [19:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   state_e      r_state;
   logic [3:0]  r_cnt;
   logic        r_ready;
   logic        r_respValid;
   logic [31:0] r_rdata;
   logic [31:0] r_wdata;
   logic        r_dataOe;
   logic [19:0] r_ramAddr;
   logic [3:0]  r_ramBeN;
   logic        r_ceN;
   logic        r_oeN;
   logic        r_weN;

   // Byte-lane and out-of-window address bits are decoded upstream by the arbiter.
   logic w_unusedAddrBits;
   assign w_unusedAddrBits = ^{req_addr[31:22], req_addr[1:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_ready     <= 1'b0;
         r_respValid <= 1'b0;
         r_rdata     <= 32'd0;
         r_wdata     <= 32'd0;
         r_dataOe    <= 1'b0;
         r_ramAddr   <= 20'd0;
         r_ramBeN    <= 4'hF;
         r_ceN       <= 1'b1;
         r_oeN       <= 1'b1;
         r_weN       <= 1'b1;
      end else begin
         r_respValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               if (req_valid && r_ready) begin
                  r_ready   <= 1'b0;
                  r_ramAddr <= req_addr[21:2];
                  r_ceN     <= 1'b0;
                  if (req_we) begin
                     r_state  <= S_WR_SU;
                     r_cnt    <= cntLoad(WR_SETUP);
                     r_wdata  <= req_wdata;
                     r_dataOe <= 1'b1;
                     r_ramBeN <= ~req_be;
                  end else begin
                     r_state  <= S_RD;
                     r_cnt    <= cntLoad(READ_WAIT);
                     r_oeN    <= 1'b0;
                     r_ramBeN <= 4'h0;
                  end
               end
            end
            S_RD: begin
               if (r_cnt == 4'd0) begin
                  r_rdata     <= ram_data;
                  r_respValid <= 1'b1;
                  r_ready     <= 1'b1;
                  r_state     <= S_IDLE;
                  r_ceN       <= 1'b1;
                  r_oeN       <= 1'b1;
                  r_ramBeN    <= 4'hF;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_WR_SU: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_WR_PL;
                  r_cnt   <= cntLoad(WR_PULSE);
                  r_weN   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_WR_PL: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_WR_HD;
                  r_cnt   <= cntLoad(WR_HOLD);
                  r_weN   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_WR_HD: begin
               // Data stays on the bus through hold so the SRAM latches it on the rising we_n.
               if (r_cnt == 4'd0) begin
                  r_respValid <= 1'b1;
                  r_ready     <= 1'b1;
                  r_state     <= S_IDLE;
                  r_dataOe    <= 1'b0;
                  r_ceN       <= 1'b1;
                  r_ramBeN    <= 4'hF;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ram_data   = r_dataOe ? r_wdata : 32'bz;
   assign req_ready  = r_ready;
   assign resp_valid = r_respValid;
   assign resp_rdata = r_rdata;
   assign ram_addr   = r_ramAddr;
   assign ram_be_n   = r_ramBeN;
   assign ram_ce_n   = r_ceN;
   assign ram_oe_n   = r_oeN;
   assign ram_we_n   = r_weN;

endmodule
